// File: rtl/mem_chk_pkg.sv
// ---------------------------------------------------------------------------
// mem_chk_pkg : shared state encoding and width helpers for the store checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_chk_pkg;

   typedef enum logic [1:0] {
      CHK_IDLE = 2'd0,
      CHK_RUN  = 2'd1,
      CHK_PASS = 2'd2,
      CHK_FAIL = 2'd3
   } chk_state_t;

   // Index width never collapses to zero so a single-entry table stays legal.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Watchdog only needs to reach TIMEOUT-1.
   function automatic int wdog_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exp_table.sv
// ---------------------------------------------------------------------------
// exp_table : DEPTH x {addr,data} expected-store table, one write port,
//             one indexed read port and a parallel compare vector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exp_table #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic [ADDR_W-1:0] cmp_addr,
   input  logic [DATA_W-1:0] cmp_data,
   output logic [DEPTH-1:0]  cmp_hit
);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (wr_en && (int'(wr_idx) < DEPTH)) begin
         addr_d[wr_idx] = wr_addr;
         data_d[wr_idx] = wr_data;
      end
   end

   // Table contents carry no reset; they are only meaningful once loaded.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   always_comb begin
      rd_addr = '0;
      rd_data = '0;
      if (int'(rd_idx) < DEPTH) begin
         rd_addr = addr_q[rd_idx];
         rd_data = data_q[rd_idx];
      end
   end

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
         assign cmp_hit[i] = (addr_q[i] == cmp_addr) && (data_q[i] == cmp_data);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker : compares CPU data-memory writes against a loaded table
//                     (ordered or any-order) with a watchdog timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_write_checker
   import mem_chk_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int ORDERED = 1,
   parameter int TIMEOUT = 1000,
   localparam int IDX_W  = idx_width(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [CNT_W-1:0]  exp_count,
   input  logic              start,
   input  logic              clear,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] data_adr,
   input  logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timed_out,
   output logic [CNT_W-1:0]  match_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   localparam int WDOG_W = wdog_width(TIMEOUT);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   chk_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  match_count_q, match_count_d;
   logic [DEPTH-1:0]  mask_q, mask_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timed_out_q, timed_out_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;

   logic              tbl_we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DEPTH-1:0]  cmp_hit;
   logic [DEPTH-1:0]  valid_vec;
   logic [DEPTH-1:0]  sel_bit;
   logic              any_free;
   logic              accept;
   logic [CNT_W-1:0]  start_cnt;

   assign tbl_we    = (state_q == CHK_IDLE) && exp_we && !start && !clear;
   assign start_cnt = (exp_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : exp_count;

   exp_table #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_table (
      .clk      (clk),
      .wr_en    (tbl_we),
      .wr_idx   (exp_idx),
      .wr_addr  (exp_addr),
      .wr_data  (exp_data),
      .rd_idx   (match_count_q[IDX_W-1:0]),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .cmp_addr (data_adr),
      .cmp_data (write_data),
      .cmp_hit  (cmp_hit)
   );

   // Any-order mode claims the lowest-index still-unmatched equal entry.
   always_comb begin
      valid_vec = '0;
      sel_bit   = '0;
      any_free  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = CNT_W'(i) < count_q;
         if (cmp_hit[i] && !mask_q[i] && valid_vec[i] && !any_free) begin
            any_free   = 1'b1;
            sel_bit[i] = 1'b1;
         end
      end
      if (ORDERED != 0) begin
         accept = (rd_addr == data_adr) && (rd_data == write_data);
      end else begin
         accept = any_free;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      match_count_d = match_count_q;
      mask_d        = mask_q;
      wdog_d        = wdog_q;
      timed_out_d   = timed_out_q;
      fail_addr_d   = fail_addr_q;
      fail_data_d   = fail_data_q;
      if (clear) begin
         state_d       = CHK_IDLE;
         match_count_d = '0;
         mask_d        = '0;
         wdog_d        = '0;
         timed_out_d   = 1'b0;
         fail_addr_d   = '0;
         fail_data_d   = '0;
      end else begin
         case (state_q)
            CHK_IDLE: begin
               if (start) begin
                  count_d       = start_cnt;
                  match_count_d = '0;
                  mask_d        = '0;
                  wdog_d        = '0;
                  state_d       = (start_cnt == '0) ? CHK_PASS : CHK_RUN;
               end
            end
            CHK_RUN: begin
               // A write in the expiry cycle is judged on its own merits.
               if (mem_write) begin
                  if (accept) begin
                     match_count_d = match_count_q + CNT_W'(1);
                     mask_d        = mask_q | sel_bit;
                     wdog_d        = '0;
                     if (match_count_d == count_q) begin
                        state_d = CHK_PASS;
                     end
                  end else begin
                     state_d     = CHK_FAIL;
                     fail_addr_d = data_adr;
                     fail_data_d = write_data;
                  end
               end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
                  state_d     = CHK_FAIL;
                  timed_out_d = 1'b1;
               end else if (wdog_q != '1) begin
                  wdog_d = wdog_q + WDOG_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= CHK_IDLE;
         count_q       <= '0;
         match_count_q <= '0;
         mask_q        <= '0;
         wdog_q        <= '0;
         timed_out_q   <= 1'b0;
         fail_addr_q   <= '0;
         fail_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         match_count_q <= match_count_d;
         mask_q        <= mask_d;
         wdog_q        <= wdog_d;
         timed_out_q   <= timed_out_d;
         fail_addr_q   <= fail_addr_d;
         fail_data_q   <= fail_data_d;
      end
   end

   assign busy        = (state_q == CHK_RUN);
   assign done        = (state_q == CHK_PASS) || (state_q == CHK_FAIL);
   assign pass        = (state_q == CHK_PASS);
   assign fail        = (state_q == CHK_FAIL);
   assign timed_out   = timed_out_q;
   assign match_count = match_count_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_write_checker : drives an in-order and an any-order checker with the
//                        same stimulus and compares both to a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        exp_we, start, clear, mem_write;
   logic [2:0]  exp_idx;
   logic [31:0] exp_addr, exp_data, data_adr, write_data;
   logic [3:0]  exp_count;

   logic        busy_o [2];
   logic        done_o [2];
   logic        pass_o [2];
   logic        fail_o [2];
   logic        to_o   [2];
   logic [3:0]  mc_o   [2];
   logic [31:0] fa_o   [2];
   logic [31:0] fd_o   [2];

   always #5 clk = ~clk;

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .ORDERED(1), .TIMEOUT(16)) u_ord (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
      .exp_data(exp_data), .exp_count(exp_count), .start(start), .clear(clear),
      .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]),
      .timed_out(to_o[0]), .match_count(mc_o[0]), .fail_addr(fa_o[0]), .fail_data(fd_o[0]));

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .ORDERED(0), .TIMEOUT(16)) u_any (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
      .exp_data(exp_data), .exp_count(exp_count), .start(start), .clear(clear),
      .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]),
      .timed_out(to_o[1]), .match_count(mc_o[1]), .fail_addr(fa_o[1]), .fail_data(fd_o[1]));

   // Reference model: phase 0 idle, 1 running, 2 passed, 3 failed.
   int          ph   [2];
   int          cnt  [2];
   int          mc   [2];
   int          wd   [2];
   bit          to   [2];
   bit          used [2][8];
   logic [31:0] ta   [2][8];
   logic [31:0] td   [2][8];
   logic [31:0] fa   [2];
   logic [31:0] fd   [2];

   int    n_checks = 0;
   int    n_errors = 0;
   string cur      = "init";

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         ph[k] = 0; cnt[k] = 0; mc[k] = 0; wd[k] = 0; to[k] = 1'b0;
         fa[k] = '0; fd[k] = '0;
         for (int i = 0; i < 8; i++) used[k][i] = 1'b0;
      end
   endfunction

   function automatic void model_update();
      int j;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         if (clear) begin
            ph[k] = 0; mc[k] = 0; wd[k] = 0; to[k] = 1'b0; fa[k] = '0; fd[k] = '0;
            for (int i = 0; i < 8; i++) used[k][i] = 1'b0;
         end else if (ph[k] == 0) begin
            if (start) begin
               cnt[k] = (int'(exp_count) > 8) ? 8 : int'(exp_count);
               mc[k] = 0; wd[k] = 0;
               for (int i = 0; i < 8; i++) used[k][i] = 1'b0;
               ph[k] = (cnt[k] == 0) ? 2 : 1;
            end else if (exp_we) begin
               ta[k][exp_idx] = exp_addr;
               td[k][exp_idx] = exp_data;
            end
         end else if (ph[k] == 1) begin
            if (mem_write) begin
               j = -1;
               if (k == 0) begin
                  if (ta[k][mc[k]] == data_adr && td[k][mc[k]] == write_data) j = mc[k];
               end else begin
                  for (int i = 0; i < cnt[k]; i++)
                     if (j < 0 && !used[k][i] && ta[k][i] == data_adr && td[k][i] == write_data)
                        j = i;
               end
               if (j >= 0) begin
                  used[k][j] = 1'b1;
                  mc[k]++;
                  wd[k] = 0;
                  if (mc[k] == cnt[k]) ph[k] = 2;
               end else begin
                  ph[k] = 3; fa[k] = data_adr; fd[k] = write_data;
               end
            end else if (wd[k] == 15) begin
               ph[k] = 3; to[k] = 1'b1;
            end else begin
               wd[k]++;
            end
         end
      end
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s/%s/dut%0d observed=%0h expected=%0h", cur, nm, k, obs, expv);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk("busy",        k, 32'(busy_o[k]), 32'(ph[k] == 1));
         chk("done",        k, 32'(done_o[k]), 32'(ph[k] >= 2));
         chk("pass",        k, 32'(pass_o[k]), 32'(ph[k] == 2));
         chk("fail",        k, 32'(fail_o[k]), 32'(ph[k] == 3));
         chk("timed_out",   k, 32'(to_o[k]),   32'(to[k]));
         chk("match_count", k, 32'(mc_o[k]),   32'(mc[k]));
         chk("fail_addr",   k, fa_o[k],        fa[k]);
         chk("fail_data",   k, fd_o[k],        fd[k]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_all();
      @(negedge clk);
      exp_we = 1'b0; start = 1'b0; clear = 1'b0; mem_write = 1'b0;
   endtask

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
      exp_we = 1'b1; exp_idx = 3'(i); exp_addr = a; exp_data = d;
      tick();
   endtask

   task automatic go(input int c);
      start = 1'b1; exp_count = 4'(c);
      tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; data_adr = a; write_data = d;
      tick();
   endtask

   task automatic clr();
      clear = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      int e;
      reset = 1'b1; exp_we = 1'b0; start = 1'b0; clear = 1'b0; mem_write = 1'b0;
      exp_idx = '0; exp_addr = '0; exp_data = '0; exp_count = '0;
      data_adr = '0; write_data = '0;
      model_reset();
      #1 reset = 1'b0;
      #1 cur = "reset";
      check_all();
      @(negedge clk);
      reset = 1'b1;

      cur = "single";
      load(0, 20, 2); go(1); wr(20, 2); tick();

      cur = "ordered_reject";
      clr(); load(0, 100, 7); load(1, 104, 9); go(2); wr(104, 9); tick();

      cur = "any_order_dup";
      clr(); load(0, 100, 7); load(1, 104, 9); load(2, 100, 7); go(3);
      wr(100, 7); wr(104, 9); wr(100, 7); wr(100, 7); tick();

      cur = "timeout";
      clr(); load(0, 20, 2); go(1);
      repeat (17) tick();
      cur = "write_beats_timeout";
      clr(); go(1);
      repeat (15) tick();
      wr(20, 2); tick();

      cur = "count_zero";
      clr(); go(0); tick();
      cur = "count_clamp";
      clr();
      for (int i = 0; i < 8; i++) load(i, 32'(1000 + 4 * i), $urandom);
      go(12);
      for (int i = 0; i < 8; i++) wr(ta[0][i], td[0][i]);
      tick();

      cur = "async_reset";
      clr(); load(0, 20, 2); load(1, 24, 3); go(2); wr(20, 2);
      reset = 1'b0;
      model_reset();
      #1 check_all();
      #1 reset = 1'b1;
      tick();

      cur = "clear_reuse";
      load(0, 20, 2); load(1, 24, 3); go(2); wr(24, 3); wr(99, 99); tick();
      clr(); go(2); wr(20, 2); wr(24, 3); tick();

      cur = "ignored_ctrl";
      clr(); go(2); load(0, 55, 55); go(1); wr(20, 2); wr(24, 3); tick();

      for (int it = 0; it < 12; it++) begin
         cur = $sformatf("random%0d", it);
         clr();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) load(i, 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 3)));
         mem_write = ($urandom_range(0, 1) == 1); data_adr = ta[0][0]; write_data = td[0][0];
         go(n);
         for (int w = 0; w <= n; w++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            if ($urandom_range(0, 9) < 8) begin
               e = (it % 2 == 0) ? ((w < n) ? w : 0) : $urandom_range(0, n - 1);
               wr(ta[0][e], td[0][e]);
            end else begin
               wr(32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 3)));
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
